// File: rtl/vive_uart_arbiter_pkg.sv
// Shared constants, FSM encoding and packet framing helper for the Vive UART arbiter.
package vive_uart_arbiter_pkg;

  localparam logic [7:0]  PKT_HDR          = 8'hA0;
  localparam int unsigned PKT_LEN          = 5;
  localparam int unsigned PKT_WORD_W       = 17;
  localparam int unsigned CH_W             = 2;
  localparam int unsigned BUSY_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitHi,
    StWaitLo
  } arb_state_e;

  // Byte idx of the 5-byte packet for word w from channel ch; byte 4 is the XOR checksum.
  function automatic logic [7:0] pkt_byte(input logic [CH_W-1:0]       ch,
                                          input logic [PKT_WORD_W-1:0] w,
                                          input logic [2:0]            idx);
    logic [7:0] b0, b1, b2, b3;
    b0 = PKT_HDR | {6'b0, ch};
    b1 = {7'b0, w[16]};
    b2 = w[15:8];
    b3 = w[7:0];
    case (idx)
      3'd0:    pkt_byte = b0;
      3'd1:    pkt_byte = b1;
      3'd2:    pkt_byte = b2;
      3'd3:    pkt_byte = b3;
      default: pkt_byte = b0 ^ b1 ^ b2 ^ b3;
    endcase
  endfunction

endpackage

// File: rtl/vive_uart_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module vive_uart_arbiter_rr_arbiter #(
  parameter int unsigned NumCh = 3,
  parameter int unsigned IdxW  = 2
) (
  input  logic [NumCh-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NumCh-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] c;
    sum     = '0;
    c       = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      // ptr_i < NumCh, so a single subtraction performs the wrap.
      sum = {1'b0, ptr_i} + (IdxW+1)'(i);
      if (sum >= (IdxW+1)'(NumCh)) sum = sum - (IdxW+1)'(NumCh);
      c = sum[IdxW-1:0];
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/vive_uart_arbiter.sv
// Shares one uart_tx among NUM_CH receiver channels: buffers one word per channel and
// sends each as a 5-byte packet using a tx_start/tx_busy handshake, round-robin.
module vive_uart_arbiter
  import vive_uart_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned WORD_W       = 17,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                     clk_25MHz,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        word_valid,
  input  logic [NUM_CH*WORD_W-1:0] word_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [NUM_CH-1:0]        overflow,
  output logic [7:0]               drop_count,
  output logic                     idle
);

  localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   pkt_ch_q, pkt_ch_d;
  logic [WORD_W-1:0] pkt_word_q, pkt_word_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [WORD_W-1:0] buf_q [NUM_CH];
  logic [WORD_W-1:0] buf_d [NUM_CH];
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [NUM_CH-1:0] gnt_oh;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              take;
  logic              advance;
  logic [NUM_CH-1:0] drop;
  logic [2:0]        n_drop;
  logic [8:0]        drop_sum;

  vive_uart_arbiter_rr_arbiter #(
    .NumCh (NUM_CH),
    .IdxW  (CH_W)
  ) u_rr_arbiter (
    .req_i   (pend_q),
    .ptr_i   (rr_q),
    .gnt_o   (gnt_oh),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // State register
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tmr_q        <= '0;
      rr_q         <= '0;
      pkt_ch_q     <= '0;
      pkt_word_q   <= '0;
      pend_q       <= '0;
      overflow_q   <= '0;
      drop_count_q <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      rr_q         <= rr_d;
      pkt_ch_q     <= pkt_ch_d;
      pkt_word_q   <= pkt_word_d;
      pend_q       <= pend_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Buffer contents are qualified by pend_q, so they need no reset.
  always_ff @(posedge clk_25MHz) begin
    for (int unsigned k = 0; k < NUM_CH; k++) buf_q[k] <= buf_d[k];
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    rr_d       = rr_q;
    pkt_ch_d   = pkt_ch_q;
    pkt_word_d = pkt_word_q;
    take       = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid && !tx_busy) begin
          take       = 1'b1;
          pkt_ch_d   = gnt_idx;
          pkt_word_d = buf_q[gnt_idx];
          idx_d      = '0;
          rr_d       = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
          state_d    = StStart;
        end
      end
      StStart: begin
        tmr_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (tx_busy) begin
          state_d = StWaitLo;
        end else if (tmr_q == TmrW'(BUSY_TIMEOUT - 1)) begin
          advance = 1'b1;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StWaitLo: begin
        if (!tx_busy) advance = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      if (idx_q == 3'(PKT_LEN - 1)) begin
        state_d = StIdle;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = StStart;
      end
    end
  end

  // Holding buffers: a capture in the grant cycle wins over the clear.
  always_comb begin
    n_drop = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pend_d[k] = pend_q[k];
      buf_d[k]  = buf_q[k];
      drop[k]   = 1'b0;
      if (take && gnt_oh[k]) pend_d[k] = 1'b0;
      if (word_valid[k]) begin
        if (pend_q[k] && !(take && gnt_oh[k])) begin
          drop[k] = 1'b1;
        end else begin
          pend_d[k] = 1'b1;
          buf_d[k]  = word_data[k*WORD_W +: WORD_W];
        end
      end
      n_drop = n_drop + 3'(drop[k]);
    end
    overflow_d   = overflow_q | drop;
    drop_sum     = {1'b0, drop_count_q} + 9'(n_drop);
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Outputs: tx_start/tx_data are registered from the next state.
  always_comb begin
    tx_start_d = (state_d == StStart);
    tx_data_d  = tx_start_d ? pkt_byte(pkt_ch_d, pkt_word_d, idx_d) : tx_data_q;
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign idle       = (state_q == StIdle) && !(|pend_q);

endmodule
